alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//   Multi-cycle ALU; sink of the 3-bit ALUControl code from the ALU control decoder.
//   Takes an operation and two operands over a valid/ready handshake and returns
//   ALUResult plus Zero (used for branch compare) over a second valid/ready handshake.
//   Shifts are computed serially, one bit per cycle; all other ops take one cycle.
// PARAMETERS
//   WIDTH  32  operand/result width; shift amount is SrcB[$clog2(WIDTH)-1:0]
// PORTS
//   clk         in   1      clock, all state on rising edge
//   rst         in   1      synchronous, active-high reset
//   in_valid    in   1      ALUControl/SrcA/SrcB valid
//   in_ready    out  1      unit can accept an operation
//   ALUControl  in   3      000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
//   SrcA        in   WIDTH  operand A
//   SrcB        in   WIDTH  operand B (shift amount for sll/srl)
//   out_valid   out  1      ALUResult/Zero valid
//   out_ready   in   1      consumer accepts result
//   ALUResult   out  WIDTH  registered result
//   Zero        out  1      registered (ALUResult == 0)
// BEHAVIOUR
//   Reset: state IDLE; in_ready=1 after reset release; out_valid=0, ALUResult=0, Zero=0,
//     shift counter=0. Reset mid-SHIFT or mid-DONE discards the op; no result emitted.
//   States: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//   Accept = in_valid & in_ready; operands and op are latched at accept; inputs ignored otherwise.
//   IDLE, accept, op not shift: compute result, load ALUResult/Zero -> DONE.
//     out_valid rises the cycle after accept (latency 1).
//   IDLE, accept, sll/srl, shamt==0: ALUResult=SrcA -> DONE (latency 1).
//   IDLE, accept, sll/srl, shamt!=0: load work reg=SrcA, counter=shamt -> SHIFT.
//   SHIFT: each cycle shift work reg 1 bit (sll: left, zero fill; srl: logical right,
//     zero fill), counter-1; on the cycle counter goes 1->0 load ALUResult/Zero -> DONE.
//     out_valid rises shamt+1 cycles after accept; shamt=WIDTH-1 -> WIDTH cycles.
//   DONE: hold ALUResult/Zero/out_valid stable until out_ready=1; on that edge -> IDLE.
//     No new accept in the handoff cycle (in_ready=0 in DONE); next accept earliest one
//     cycle later. out_ready is ignored outside DONE.
//   Arithmetic: add/sub modulo 2^WIDTH, no carry/overflow output. slt signed
//     two's-complement compare, result 1 or 0 zero-extended. and/or/xor bitwise.
//     Only SrcB[$clog2(WIDTH)-1:0] used for shifts; upper SrcB bits ignored.
//   Zero is computed from the final ALUResult in the same cycle it is loaded.
//   ALUResult keeps its last value in IDLE/SHIFT (undefined to consumers when out_valid=0).
// TESTING
//   add 5,7 -> out_valid 1 cycle after accept, ALUResult=12, Zero=0.
//   sub 9,9 -> ALUResult=0, Zero=1; slt 0xFFFFFFFF,1 -> 1; slt 1,0xFFFFFFFF -> 0.
//   sll 1 by 31 -> 0x80000000 after 32 cycles; srl 0x80000000 by SrcB=0x24 (shamt 4)
//     -> 0x08000000 after 5 cycles; sll 0xA5 by 0 -> 0xA5 after 1 cycle.
//   out_ready low 3 cycles in DONE -> result/out_valid stable, in_ready=0, in_valid ignored.
//   rst asserted during SHIFT (shamt 20, cycle 5) -> next cycle IDLE, out_valid=0,
//     ALUResult=0; following add 2,3 -> 5 with latency 1.
//   Back-to-back: in_valid held high with 3 ops -> each accepted one cycle after the prior
//     result handoff; results in order, none dropped or duplicated.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU with valid/ready handshakes and serial one-bit-per-cycle shifts
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;

    logic [1:0]       state;
    logic             right;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] work, nxt_work, alu_res;
    logic [SW-1:0]    shamt;
    logic             accept, is_shift;

    assign shamt     = SrcB[SW-1:0];
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready;
    assign is_shift  = ALUControl[2:1] == 2'b11;
    assign nxt_work  = right ? work >> 1 : work << 1;

    // Shift ops only reach this path with shamt==0, where the result is SrcA unchanged
    always_comb begin
        alu_res = ALUControl == 3'b000 ? SrcA + SrcB :
                  ALUControl == 3'b001 ? SrcA - SrcB :
                  ALUControl == 3'b010 ? SrcA & SrcB :
                  ALUControl == 3'b011 ? SrcA | SrcB :
                  ALUControl == 3'b100 ? SrcA ^ SrcB :
                  ALUControl == 3'b101 ? {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)} :
                  SrcA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            right     <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            ALUResult <= '0;
            Zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (is_shift && shamt != '0) begin
                        work  <= SrcA;
                        cnt   <= shamt;
                        right <= ALUControl[0];
                        state <= SHIFT;
                    end else begin
                        ALUResult <= alu_res;
                        Zero      <= alu_res == '0;
                        state     <= DONE;
                    end
                end
                SHIFT: begin
                    work <= nxt_work;
                    cnt  <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        ALUResult <= nxt_work;
                        Zero      <= nxt_work == '0;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
